// File: rtl/truncation_sram_pkg.sv
// Shared constants and state type for the truncation SRAM sequencer.
package truncation_sram_pkg;

  localparam int ADDR_W         = 10;
  localparam int DATA_W         = 32;
  localparam int NUM_WL         = 1024;
  localparam int DEF_PRE_CYCLES = 2;
  localparam int DEF_WL_CYCLES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_GAP,
    ST_ACCESS,
    ST_SENSE,
    ST_RESP
  } ctrl_state_e;

endpackage

// File: rtl/truncation_wl_decode.sv
// Combinational 10-to-1024 one-hot wordline decoder with enable.
module truncation_wl_decode
  import truncation_sram_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [NUM_WL-1:0] wl
);

  // Raise exactly the addressed wordline when enabled, otherwise all low.
  always_comb begin
    wl = '0;
    if (en) begin
      wl[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/truncation_sram_ctrl.sv
// Request sequencer for the truncation SRAM macro: precharge, gap,
// wordline access, optional sense cycle, then a held response.
module truncation_sram_ctrl
  import truncation_sram_pkg::*;
#(
  parameter int PRE_CYCLES = DEF_PRE_CYCLES,
  parameter int WL_CYCLES  = DEF_WL_CYCLES
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_trunc,
  input  logic              req_tail,
  input  logic              req_byte_mode,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_pre,
  output logic              sram_readen,
  output logic              sram_writeen,
  output logic              sram_tail,
  output logic              sram_byte_en_b,
  output logic [DATA_W-1:0] sram_din,
  output logic [DATA_W-1:0] sram_trunc,
  output logic [NUM_WL-1:0] sram_wl,
  input  logic [DATA_W-1:0] sram_dout
);

  localparam int MAX_CYCLES = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WL_LOAD  = CNT_W'(WL_CYCLES - 1);

  ctrl_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic              accept;
  logic              access_d;
  logic              pre_d;
  logic              readen_d;
  logic              writeen_d;
  logic              rsp_valid_d;
  logic              ready_d;
  logic [NUM_WL-1:0] wl_d;

  assign accept = req_valid && req_ready;

  // Next state, phase counter reload on every state entry, and the next
  // values of all registered macro/handshake outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_PRE;
      ST_PRE:    if (cnt_q == '0) state_d = ST_GAP;
                 else cnt_d = cnt_q - 1'b1;
      ST_GAP:    state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == '0) state_d = we_q ? ST_RESP : ST_SENSE;
                 else cnt_d = cnt_q - 1'b1;
      ST_SENSE:  state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      case (state_d)
        ST_PRE:    cnt_d = PRE_LOAD;
        ST_ACCESS: cnt_d = WL_LOAD;
        default:   cnt_d = '0;
      endcase
    end
    pre_d       = (state_d == ST_PRE);
    access_d    = (state_d == ST_ACCESS);
    writeen_d   = access_d && we_q;
    readen_d    = !we_q && (access_d || (state_d == ST_SENSE));
    rsp_valid_d = (state_d == ST_RESP);
    ready_d     = (state_d == ST_IDLE);
  end

  truncation_wl_decode u_wl_decode (
    .addr (addr_q),
    .en   (access_d),
    .wl   (wl_d)
  );

  // State register plus registered strobes so every pin seen by the macro
  // is glitch-free; read data is captured at the end of the sense cycle.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sram_pre     <= 1'b0;
      sram_readen  <= 1'b0;
      sram_writeen <= 1'b0;
      sram_wl      <= '0;
      rsp_valid    <= 1'b0;
      rsp_we       <= 1'b0;
      rsp_rdata    <= '0;
      req_ready    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sram_pre     <= pre_d;
      sram_readen  <= readen_d;
      sram_writeen <= writeen_d;
      sram_wl      <= wl_d;
      rsp_valid    <= rsp_valid_d;
      rsp_we       <= rsp_valid_d && we_q;
      req_ready    <= ready_d;
      if (state_q == ST_SENSE) begin
        rsp_rdata <= sram_dout;
      end
    end
  end

  // Request fields are captured only on accept and then held stable for the
  // whole operation and beyond, until the next accept.
  always_ff @(posedge wb_clk_i) begin
    if (!rst_n) begin
      addr_q         <= '0;
      we_q           <= 1'b0;
      sram_din       <= '0;
      sram_trunc     <= '0;
      sram_tail      <= 1'b0;
      sram_byte_en_b <= 1'b1;
    end else if (accept) begin
      addr_q         <= req_addr;
      we_q           <= req_we;
      sram_din       <= req_wdata;
      sram_trunc     <= req_trunc;
      sram_tail      <= req_tail;
      sram_byte_en_b <= ~req_byte_mode;
    end
  end

endmodule

// File: tb/tb_truncation_sram_ctrl.sv
// Scoreboard bench for truncation_sram_ctrl: a behavioural macro model,
// a cycle-timeline reference derived from the request timing rules, and
// a monitor that checks every cycle.
module tb_truncation_sram_ctrl;

  localparam int P = 2;
  localparam int W = 2;

  logic          wb_clk_i = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [9:0]    req_addr;
  logic [31:0]   req_wdata;
  logic [31:0]   req_trunc;
  logic          req_tail;
  logic          req_byte_mode;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_we;
  logic [31:0]   rsp_rdata;
  logic          sram_pre;
  logic          sram_readen;
  logic          sram_writeen;
  logic          sram_tail;
  logic          sram_byte_en_b;
  logic [31:0]   sram_din;
  logic [31:0]   sram_trunc;
  logic [1023:0] sram_wl;
  logic [31:0]   sram_dout = 32'h0;

  typedef struct {
    bit          we;
    logic [9:0]  addr;
    logic [31:0] rdata;
    int          acc;
  } txn_t;

  txn_t        sb[$];
  txn_t        mon_t;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          rst_hit = 1'b0;
  bit          rsp_eager = 1'b0;
  int          k;
  int          lat;
  bit          exp_acc;
  logic [31:0] ref_mem [1024];
  logic [31:0] macro_mem [1024];
  logic [31:0] exp_din = 32'h0;
  logic [31:0] exp_trunc = 32'h0;
  bit          exp_tail = 1'b0;
  bit          exp_byte_b = 1'b1;
  logic [31:0] last_rdata = 32'h0;

  truncation_sram_ctrl #(.PRE_CYCLES(P), .WL_CYCLES(W)) dut (
    .wb_clk_i       (wb_clk_i),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_trunc      (req_trunc),
    .req_tail       (req_tail),
    .req_byte_mode  (req_byte_mode),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_we         (rsp_we),
    .rsp_rdata      (rsp_rdata),
    .sram_pre       (sram_pre),
    .sram_readen    (sram_readen),
    .sram_writeen   (sram_writeen),
    .sram_tail      (sram_tail),
    .sram_byte_en_b (sram_byte_en_b),
    .sram_din       (sram_din),
    .sram_trunc     (sram_trunc),
    .sram_wl        (sram_wl),
    .sram_dout      (sram_dout)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Summarise a wordline vector: index if one-hot, 'h800 if idle, 'hFFF otherwise.
  function automatic int wl_code(logic [1023:0] v);
    if (v == '0) return 'h800;
    if (!$onehot(v)) return 'hFFF;
    for (int i = 0; i < 1024; i++) begin
      if (v[i]) return i;
    end
    return 'hFFF;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter and record of whether the last edge applied reset.
  always @(posedge wb_clk_i) begin
    cyc     <= cyc + 1;
    rst_hit <= !rst_n;
  end

  // Behavioural macro: write on writeen with an active wordline, sense on readen.
  always @(posedge wb_clk_i) begin
    if (wl_code(sram_wl) < 1024) begin
      if (sram_writeen) macro_mem[wl_code(sram_wl)] = sram_din;
      if (sram_readen) sram_dout <= macro_mem[wl_code(sram_wl)];
    end
  end

  // Monitor: invariants, stable fields, and per-cycle expected timeline.
  always @(negedge wb_clk_i) begin
    if (rst_hit) begin
      sb.delete();
      exp_din    = 32'h0;
      exp_trunc  = 32'h0;
      exp_tail   = 1'b0;
      exp_byte_b = 1'b1;
      last_rdata = 32'h0;
      checkOutput("rst_pre", sram_pre, 0);
      checkOutput("rst_wl", wl_code(sram_wl), 'h800);
      checkOutput("rst_readen", sram_readen, 0);
      checkOutput("rst_writeen", sram_writeen, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_we", rsp_we, 0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 0);
      checkOutput("rst_req_ready", req_ready, 1);
      checkOutput("rst_byte_en_b", sram_byte_en_b, 1);
      checkOutput("rst_din", sram_din, 0);
      checkOutput("rst_trunc", sram_trunc, 0);
      checkOutput("rst_tail", sram_tail, 0);
    end else begin
      checkOutput("inv_onehot0", $onehot0(sram_wl), 1);
      checkOutput("inv_pre_excl", sram_pre && ((|sram_wl) || sram_readen || sram_writeen), 0);
      checkOutput("inv_rw_excl", sram_readen && sram_writeen, 0);
      checkOutput("din", sram_din, exp_din);
      checkOutput("trunc", sram_trunc, exp_trunc);
      checkOutput("tail", sram_tail, exp_tail);
      checkOutput("byte_en_b", sram_byte_en_b, exp_byte_b);
      if (sb.size() > 0) begin
        mon_t   = sb[0];
        k       = cyc - mon_t.acc + 1;
        lat     = mon_t.we ? (P + W + 2) : (P + W + 3);
        exp_acc = (k >= P + 2) && (k <= P + 1 + W);
        checkOutput("pre", sram_pre, (k <= P));
        checkOutput("wl", wl_code(sram_wl), exp_acc ? 64'(mon_t.addr) : 64'h800);
        checkOutput("writeen", sram_writeen, mon_t.we && exp_acc);
        checkOutput("readen", sram_readen, !mon_t.we && (exp_acc || k == P + W + 2));
        checkOutput("rsp_valid", rsp_valid, (k >= lat));
        checkOutput("req_ready_busy", req_ready, 0);
        if (k >= lat) begin
          checkOutput("rsp_we", rsp_we, mon_t.we);
          checkOutput("rsp_rdata", rsp_rdata, mon_t.we ? last_rdata : mon_t.rdata);
          if (rsp_ready) begin
            if (!mon_t.we) last_rdata = mon_t.rdata;
            void'(sb.pop_front());
          end
        end
      end else begin
        checkOutput("idle_pre", sram_pre, 0);
        checkOutput("idle_wl", wl_code(sram_wl), 'h800);
        checkOutput("idle_readen", sram_readen, 0);
        checkOutput("idle_writeen", sram_writeen, 0);
        checkOutput("idle_rsp_valid", rsp_valid, 0);
        checkOutput("idle_req_ready", req_ready, 1);
        checkOutput("idle_rsp_rdata", rsp_rdata, last_rdata);
      end
    end
  end

  task automatic waitResponse(input int hold, input bit poke);
    bit done = 1'b0;
    bit hit;
    int n = 0;
    while (!done && n < 300) begin
      if (hold > 0) rsp_ready = 1'b0;
      else rsp_ready = rsp_eager ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (poke && hold > 0) begin
        req_valid = 1'b1;
        req_we    = $urandom_range(0, 1);
        req_addr  = 10'($urandom);
        req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      if (rsp_valid && hold > 0) hold--;
      hit = rsp_valid && rsp_ready;
      @(posedge wb_clk_i); #2;
      n++;
      if (hit) done = 1'b1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checkOutput("rsp_timeout", done, 1);
  endtask

  // Issue one request, record its expected outcome, and optionally wait for
  // the response (hold = response cycles withheld, negative = don't wait).
  task automatic applyStimulus(input bit we, input logic [9:0] addr, input logic [31:0] wdata,
                               input logic [31:0] trunc, input bit tail, input bit bm,
                               input int hold, input bit poke);
    bit   ok = 1'b0;
    bit   rdy;
    txn_t t;
    req_we        = we;
    req_addr      = addr;
    req_wdata     = wdata;
    req_trunc     = trunc;
    req_tail      = tail;
    req_byte_mode = bm;
    req_valid     = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      rdy = req_ready;
      @(posedge wb_clk_i); #2;
      if (rdy) ok = 1'b1;
    end
    req_valid = 1'b0;
    checkOutput("accept_timeout", ok, 1);
    if (ok) begin
      t.we    = we;
      t.addr  = addr;
      t.rdata = ref_mem[addr];
      t.acc   = cyc;
      sb.push_back(t);
      if (we) ref_mem[addr] = wdata;
      exp_din    = wdata;
      exp_trunc  = trunc;
      exp_tail   = tail;
      exp_byte_b = !bm;
      if (hold >= 0) waitResponse(hold, poke);
    end
  endtask

  initial begin
    logic [9:0] a;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i]   = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
      macro_mem[i] = (i * 32'h9E3779B9) ^ 32'h5A5A0000;
    end
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_trunc = '0; req_tail = 1'b0; req_byte_mode = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #2 rst_n = 1'b1;
    @(posedge wb_clk_i); #2;

    $display("[TB] directed write/read at 0x3FF");
    applyStimulus(1'b1, 10'h3FF, 32'hDEADBEEF, 32'h0000FFFF, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 10'h3FF, 32'h0, 32'h0, 1'b1, 1'b0, 0, 1'b0);

    $display("[TB] byte mode request");
    applyStimulus(1'b1, 10'h055, 32'h12345678, 32'hF0F0F0F0, 1'b1, 1'b1, 3, 1'b0);
    repeat (5) @(posedge wb_clk_i);
    #2;

    $display("[TB] backpressure on read of addr 0");
    applyStimulus(1'b0, 10'h000, 32'h0, 32'h0, 1'b0, 1'b0, 10, 1'b1);

    $display("[TB] reset during access of addr 512");
    applyStimulus(1'b1, 10'd512, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, -1, 1'b0);
    repeat (3) @(posedge wb_clk_i);
    #2 rst_n = 1'b0;
    @(posedge wb_clk_i);
    #2 rst_n = 1'b1;
    repeat (20) @(posedge wb_clk_i);
    #2;

    $display("[TB] random requests");
    for (int i = 0; i < 1000; i++) begin
      rsp_eager = (i >= 500);
      a = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
      if (a == 10'd512) a = 10'd513;
      applyStimulus($urandom_range(0, 1), a, $urandom, $urandom,
                    $urandom_range(0, 1), $urandom_range(0, 1), 0, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge wb_clk_i);
        #2;
      end
    end

    repeat (5) @(posedge wb_clk_i);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
